// File: rtl/vga_sync_gen.sv
// vga_sync_gen
// ------------
// Free-running VGA raster timing generator. Owns the horizontal (h) and
// vertical (v) counters, drives the sync pins and produces the HReset/VReset
// strobes that the drawing blocks use to track their own pixel coordinates.
//
// Ports
//   i_Clk      pixel clock, rising-edge active
//   i_Rst_n    asynchronous active-low reset, forces the raster to (0,0)
//   i_ClkEn    pixel advance enable; everything holds while low
//   o_HSync    horizontal sync pin (p_SYNC_ACTIVE during the sync pulse)
//   o_VSync    vertical sync pin (p_SYNC_ACTIVE during the sync lines)
//   o_HReset   high during the last pixel of every line
//   o_VReset   high for the whole last line of the frame
//   o_Visible  high inside the visible window
//   o_X, o_Y   current column / row
//
// All outputs are registered and cycle-aligned with the counters: the decode
// is computed from the next counter values and loaded on the same edge as
// the counters themselves, so no output lags its coordinate.
module vga_sync_gen #(
  parameter int   p_H_VISIBLE   = 640,
  parameter int   p_H_FRONT     = 16,
  parameter int   p_H_SYNC      = 96,
  parameter int   p_H_BACK      = 48,
  parameter int   p_V_VISIBLE   = 480,
  parameter int   p_V_FRONT     = 10,
  parameter int   p_V_SYNC      = 2,
  parameter int   p_V_BACK      = 33,
  parameter logic p_SYNC_ACTIVE = 1'b0
) (
  input  logic       i_Clk,
  input  logic       i_Rst_n,
  input  logic       i_ClkEn,
  output logic       o_HSync,
  output logic       o_VSync,
  output logic       o_HReset,
  output logic       o_VReset,
  output logic       o_Visible,
  output logic [9:0] o_X,
  output logic [9:0] o_Y
);

  localparam int H_TOTAL = p_H_VISIBLE + p_H_FRONT + p_H_SYNC + p_H_BACK;
  localparam int V_TOTAL = p_V_VISIBLE + p_V_FRONT + p_V_SYNC + p_V_BACK;

  // Boundaries are kept 11 bits wide so a sync window ending exactly at
  // 1024 still compares correctly against a 10-bit counter.
  localparam logic [9:0]  L_H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0]  L_V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [10:0] L_H_VIS      = 11'(p_H_VISIBLE);
  localparam logic [10:0] L_V_VIS      = 11'(p_V_VISIBLE);
  localparam logic [10:0] L_HS_START   = 11'(p_H_VISIBLE + p_H_FRONT);
  localparam logic [10:0] L_HS_END     = 11'(p_H_VISIBLE + p_H_FRONT + p_H_SYNC);
  localparam logic [10:0] L_VS_START   = 11'(p_V_VISIBLE + p_V_FRONT);
  localparam logic [10:0] L_VS_END     = 11'(p_V_VISIBLE + p_V_FRONT + p_V_SYNC);

  logic [9:0] r_h;
  logic [9:0] r_v;
  logic       r_HSync;
  logic       r_VSync;
  logic       r_HReset;
  logic       r_VReset;
  logic       r_Visible;

  logic [9:0] w_h_nxt;
  logic [9:0] w_v_nxt;
  logic       w_hsync_nxt;
  logic       w_vsync_nxt;
  logic       w_hreset_nxt;
  logic       w_vreset_nxt;
  logic       w_visible_nxt;

  // Next raster position: h wraps at the end of the line and carries into v,
  // which wraps at the end of the frame in the same edge.
  always_comb begin
    w_h_nxt = r_h + 10'd1;
    w_v_nxt = r_v;
    if (r_h == L_H_LAST) begin
      w_h_nxt = 10'd0;
      if (r_v == L_V_LAST) begin
        w_v_nxt = 10'd0;
      end else begin
        w_v_nxt = r_v + 10'd1;
      end
    end
  end

  // Decode of the next position, registered alongside the counters.
  // VSync depends only on v, so it naturally changes only at the h wrap.
  always_comb begin
    w_visible_nxt = ({1'b0, w_h_nxt} < L_H_VIS) && ({1'b0, w_v_nxt} < L_V_VIS);
    w_hsync_nxt   = (({1'b0, w_h_nxt} >= L_HS_START) && ({1'b0, w_h_nxt} < L_HS_END))
                    ? p_SYNC_ACTIVE : ~p_SYNC_ACTIVE;
    w_vsync_nxt   = (({1'b0, w_v_nxt} >= L_VS_START) && ({1'b0, w_v_nxt} < L_VS_END))
                    ? p_SYNC_ACTIVE : ~p_SYNC_ACTIVE;
    w_hreset_nxt  = (w_h_nxt == L_H_LAST);
    w_vreset_nxt  = (w_v_nxt == L_V_LAST);
  end

  // Counter / output register stage. Reset values equal the decode of (0,0).
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_h       <= 10'd0;
      r_v       <= 10'd0;
      r_Visible <= 1'b1;
      r_HSync   <= ~p_SYNC_ACTIVE;
      r_VSync   <= ~p_SYNC_ACTIVE;
      r_HReset  <= 1'b0;
      r_VReset  <= 1'b0;
    end else if (i_ClkEn) begin
      r_h       <= w_h_nxt;
      r_v       <= w_v_nxt;
      r_Visible <= w_visible_nxt;
      r_HSync   <= w_hsync_nxt;
      r_VSync   <= w_vsync_nxt;
      r_HReset  <= w_hreset_nxt;
      r_VReset  <= w_vreset_nxt;
    end
  end

  assign o_X       = r_h;
  assign o_Y       = r_v;
  assign o_Visible = r_Visible;
  assign o_HSync   = r_HSync;
  assign o_VSync   = r_VSync;
  assign o_HReset  = r_HReset;
  assign o_VReset  = r_VReset;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Testbench for vga_sync_gen. Uses a reduced raster so that whole frames fit
// in a short run:
//   H: visible 40, front 4, sync 8, back 6  -> 58 pixels/line, HSync low X=44..51
//   V: visible 30, front 2, sync 2, back 4  -> 38 lines/frame, VSync low Y=32..33
//   frame = 58*38 = 2204 enabled cycles, visible = 40*30 = 1200 cycles.
module tb_vga_sync_gen;

  localparam int HV = 40, HF = 4, HS = 8, HB = 6;
  localparam int VV = 30, VF = 2, VS = 2, VB = 4;
  localparam int HT = 58;
  localparam int VT = 38;
  localparam int FRAME = 2204;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       hsync, vsync, hreset, vreset, visible;
  logic [9:0] x, y;

  int n_cmp = 0;
  int n_err = 0;

  vga_sync_gen #(
    .p_H_VISIBLE(HV), .p_H_FRONT(HF), .p_H_SYNC(HS), .p_H_BACK(HB),
    .p_V_VISIBLE(VV), .p_V_FRONT(VF), .p_V_SYNC(VS), .p_V_BACK(VB),
    .p_SYNC_ACTIVE(1'b0)
  ) dut (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_ClkEn(en),
    .o_HSync(hsync), .o_VSync(vsync), .o_HReset(hreset), .o_VReset(vreset),
    .o_Visible(visible), .o_X(x), .o_Y(y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {X, Y, Visible, HSync, VSync, HReset, VReset}
  function automatic logic [26:0] dut_vec();
    return {x, y, visible, hsync, vsync, hreset, vreset};
  endfunction

  function automatic logic [26:0] exp_vec(int ex, int ey);
    logic vis, hs, vs, hr, vr;
    vis = (ex < 40) && (ey < 30);
    hs  = !((ex >= 44) && (ex <= 51));
    vs  = !((ey >= 32) && (ey <= 33));
    hr  = (ex == 57);
    vr  = (ey == 37);
    return {10'(ex), 10'(ey), vis, hs, vs, hr, vr};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int mx, my;
  int c_hs_low, c_hs_xmin, c_hs_xmax, c_hr, c_hrvr, c_vis, c_vs_low, c_vs_ymin, c_vs_ymax, c_vr;
  int c_hold_hr;
  int steps;
  logic [26:0] prev;

  initial begin
    rst_n = 1'b0;
    en    = 1'b1;
    // Reset held for 5 cycles
    repeat (5) tick();
    chk("rst_X", 32'(x), 32'd0);
    chk("rst_Y", 32'(y), 32'd0);
    chk("rst_Visible", 32'(visible), 32'd1);
    chk("rst_HSync", 32'(hsync), 32'd1);
    chk("rst_VSync", 32'(vsync), 32'd1);
    chk("rst_HReset", 32'(hreset), 32'd0);
    chk("rst_VReset", 32'(vreset), 32'd0);

    // One full frame with enable high; per-cycle model check plus tallies
    rst_n = 1'b1;
    mx = 0; my = 0;
    c_hs_low = 0; c_hs_xmin = 1000; c_hs_xmax = -1; c_hr = 0; c_hrvr = 0;
    c_vis = 0; c_vs_low = 0; c_vs_ymin = 1000; c_vs_ymax = -1; c_vr = 0;
    for (int i = 0; i < FRAME; i++) begin
      tick();
      if (mx == HT - 1) begin
        mx = 0;
        my = (my == VT - 1) ? 0 : my + 1;
      end else begin
        mx = mx + 1;
      end
      chk("frame_vec", 32'(dut_vec()), 32'(exp_vec(mx, my)));
      if (!hsync) begin
        c_hs_low++;
        if (int'(x) < c_hs_xmin) c_hs_xmin = int'(x);
        if (int'(x) > c_hs_xmax) c_hs_xmax = int'(x);
      end
      if (!vsync) begin
        c_vs_low++;
        if (int'(y) < c_vs_ymin) c_vs_ymin = int'(y);
        if (int'(y) > c_vs_ymax) c_vs_ymax = int'(y);
      end
      if (hreset) c_hr++;
      if (hreset && vreset) c_hrvr++;
      if (visible) c_vis++;
      if (vreset) c_vr++;
    end
    chk("frame_end_X", 32'(x), 32'd0);
    chk("frame_end_Y", 32'(y), 32'd0);
    chk("hsync_low_cycles", 32'(c_hs_low), 32'd304);
    chk("hsync_low_xmin", 32'(c_hs_xmin), 32'd44);
    chk("hsync_low_xmax", 32'(c_hs_xmax), 32'd51);
    chk("vsync_low_cycles", 32'(c_vs_low), 32'd116);
    chk("vsync_low_ymin", 32'(c_vs_ymin), 32'd32);
    chk("vsync_low_ymax", 32'(c_vs_ymax), 32'd33);
    chk("hreset_count", 32'(c_hr), 32'd38);
    chk("hreset_vreset_count", 32'(c_hrvr), 32'd1);
    chk("visible_count", 32'(c_vis), 32'd1200);
    chk("vreset_count", 32'(c_vr), 32'd58);

    // Enable toggling 1/0: a frame takes 2*2204 clocks, outputs hold when low
    c_hold_hr = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      en = (i % 2 == 0);
      prev = dut_vec();
      tick();
      if (!en) begin
        chk("hold_vec", 32'(dut_vec()), 32'(prev));
        if (prev[1] && hreset) c_hold_hr++;
      end
    end
    en = 1'b1;
    chk("toggle_end_X", 32'(x), 32'd0);
    chk("toggle_end_Y", 32'(y), 32'd0);
    chk("held_hreset_count", 32'(c_hold_hr), 32'd38);

    // Mid-frame async reset at (30,20)
    steps = 0;
    while (!(x == 10'd30 && y == 10'd20) && steps < 3000) begin
      tick();
      steps++;
    end
    chk("reach_30_20", 32'(steps), 32'd1190);
    chk("pre_rst_vec", 32'(dut_vec()), 32'(exp_vec(30, 20)));
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_vec", 32'(dut_vec()), 32'(exp_vec(0, 0)));
    repeat (2) tick();
    chk("rst_hold_vec", 32'(dut_vec()), 32'(exp_vec(0, 0)));
    rst_n = 1'b1;
    tick();
    chk("post_rst_X", 32'(x), 32'd1);
    chk("post_rst_Y", 32'(y), 32'd0);
    chk("post_rst_VReset", 32'(vreset), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
